// File: rtl/read_dispatcher_pkg.sv
// Shared read-path definitions: symbol alphabet, read-id width and the
// default number of seeding engines.
package BwaMemDefines;

  typedef enum logic [2:0] {
    sym_A = 3'd0,
    sym_C = 3'd1,
    sym_G = 3'd2,
    sym_T = 3'd3,
    sym_N = 3'd4
  } Symbol;

  localparam int unsigned SYM_W        = $bits(Symbol);
  localparam int unsigned RID_W        = 16;
  localparam int unsigned NUM_SEED_ENG = 4;

endpackage

// File: rtl/read_dispatcher_rr_picker.sv
// Round-robin picker: grants the first requester found when searching
// upward from the engine after last_grant, wrapping modulo N.
module RrPicker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] cidx;

  // Scan candidates last_grant+1 .. last_grant+N and keep the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cidx      = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cidx = IDX_W'((32'(last_grant) + i) % N);
      if (!any && req[cidx]) begin
        any        = 1'b1;
        grant[cidx] = 1'b1;
        grant_idx  = cidx;
      end
    end
  end

endmodule

// File: rtl/read_dispatcher.sv
// Read dispatcher: holds one incoming read, claims a free seeding engine by
// round-robin, pulses its start while broadcasting the held read, and tracks
// engine claims, spurious finishes and drain requests.
module read_dispatcher
  import BwaMemDefines::*;
#(
  parameter int unsigned NUM_ENG  = NUM_SEED_ENG,
  parameter int unsigned READ_LEN = 76
) (
  input  logic                         clk,
  input  logic                         rst,
  input  Symbol                        s_read [0:READ_LEN-1],
  input  logic [RID_W-1:0]             s_read_id,
  input  logic                         s_read_valid,
  output logic                         s_read_ready,
  output Symbol                        eng_read [0:READ_LEN-1],
  output logic [RID_W-1:0]             eng_read_id,
  output logic [NUM_ENG-1:0]           eng_start,
  input  logic [NUM_ENG-1:0]           eng_finish,
  input  logic                         drain,
  output logic                         drained,
  output logic [$clog2(NUM_ENG+1)-1:0] outstanding,
  output logic                         idle,
  output logic                         err_spurious
);

  localparam int unsigned IDX_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int unsigned OUT_W = $clog2(NUM_ENG + 1);

  typedef enum logic [1:0] {S_Idle, S_WaitEng, S_Issue} state_t;

  state_t             state;
  logic [NUM_ENG-1:0] claimed;
  logic [NUM_ENG-1:0] claimed_nxt;
  logic [NUM_ENG-1:0] start_q;
  logic [NUM_ENG-1:0] grant_oh;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               grant_now;
  logic [OUT_W-1:0]   claimed_cnt;
  logic               drain_pend;

  RrPicker #(.N(NUM_ENG), .IDX_W(IDX_W)) u_rr (
    .req       (~claimed),
    .last_grant(last_grant),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign grant_now    = (state == S_WaitEng) && grant_any;
  assign s_read_ready = (state == S_Idle);
  assign idle         = (state == S_Idle) && (outstanding == '0);
  // Start is registered; masking with rst keeps a pulse already queued for
  // the issue cycle from reaching engines that are being reset alongside us.
  assign eng_start    = start_q & {NUM_ENG{~rst}};

  // Next claim map: finishes release, a grant claims and wins over a finish.
  always_comb begin
    claimed_nxt = (claimed & ~eng_finish) | (grant_now ? grant_oh : '0);
    claimed_cnt = '0;
    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      claimed_cnt = claimed_cnt + OUT_W'(claimed_nxt[i]);
    end
  end

  // Dispatch FSM: capture into hold register, wait for an engine, issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_Idle;
      start_q     <= '0;
      eng_read_id <= '0;
      last_grant  <= IDX_W'(NUM_ENG - 1);
      for (int unsigned i = 0; i < READ_LEN; i++) begin
        eng_read[i] <= sym_N;
      end
    end else begin
      start_q <= '0;
      case (state)
        S_Idle: begin
          if (s_read_valid) begin
            eng_read    <= s_read;
            eng_read_id <= s_read_id;
            state       <= S_WaitEng;
          end
        end
        S_WaitEng: begin
          if (grant_any) begin
            start_q    <= grant_oh;
            last_grant <= grant_idx;
            state      <= S_Issue;
          end
        end
        S_Issue: state <= S_Idle;
        default: state <= S_Idle;
      endcase
    end
  end

  // Claim bookkeeping, outstanding count and sticky spurious-finish flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      claimed      <= '0;
      outstanding  <= '0;
      err_spurious <= 1'b0;
    end else begin
      claimed     <= claimed_nxt;
      outstanding <= claimed_cnt;
      if (|(eng_finish & ~claimed)) begin
        err_spurious <= 1'b1;
      end
    end
  end

  // Drain tracking: answer immediately when already idle, else remember.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_pend <= 1'b0;
      drained    <= 1'b0;
    end else begin
      drained <= 1'b0;
      if ((drain || drain_pend) && idle) begin
        drained    <= 1'b1;
        drain_pend <= 1'b0;
      end else if (drain) begin
        drain_pend <= 1'b1;
      end
    end
  end

endmodule

// File: doc/read_dispatcher.md
READ_DISPATCHER -- requirements
Module: read_dispatcher

Interface
REQ-001 SHALL have parameter NUM_ENG, default 4, giving the number of seeding engines served (2..8).
REQ-002 SHALL have parameter READ_LEN, default 76, giving symbols per read.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port s_read, input, Symbol[0:READ_LEN-1]: incoming read.
REQ-006 SHALL have port s_read_id, input, RID_W: incoming read id.
REQ-007 SHALL have ports s_read_valid (input, 1) and s_read_ready (output, 1): input handshake.
REQ-008 SHALL have port eng_read, output, Symbol[0:READ_LEN-1]: read broadcast to all engines.
REQ-009 SHALL have port eng_read_id, output, RID_W: id broadcast to all engines.
REQ-010 SHALL have port eng_start, output, NUM_ENG: one-hot start pulse per engine.
REQ-011 SHALL have port eng_finish, input, NUM_ENG: per-engine one-cycle finish pulse.
REQ-012 SHALL have port drain, input, 1: one-cycle request to report when all work completes.
REQ-013 SHALL have port drained, output, 1: one-cycle pulse answering drain.
REQ-014 SHALL have port outstanding, output, $clog2(NUM_ENG+1): count of claimed engines.
REQ-015 SHALL have port idle, output, 1: high when the hold register is empty and outstanding==0.
REQ-016 SHALL have port err_spurious, output, 1: sticky flag for a finish from an unclaimed engine.

Function
REQ-017 SHALL implement the FSM S_Idle -> S_WaitEng -> S_Issue -> S_Idle.
REQ-018 S_Idle: s_read_ready=1; on s_read_valid, SHALL capture read and id into the hold register and go to S_WaitEng; s_read_ready=0 in all other states.
REQ-019 S_WaitEng: if any bit of ~claimed is set, SHALL grant one free engine k by round-robin, register eng_start one-hot at k, set claimed[k], and go to S_Issue; otherwise it SHALL stay in S_WaitEng.
REQ-020 S_Issue: eng_start SHALL be high for exactly this one cycle, with eng_read/eng_read_id stable from the hold register; the next state SHALL be S_Idle.
REQ-021 Latency SHALL be: accept at cycle T -> eng_start high at T+2 if an engine is free -> s_read_ready high again at T+3.
REQ-022 eng_read/eng_read_id SHALL be driven only from the hold register and change only on capture.
REQ-023 Round-robin SHALL search starting at (last_grant+1) mod NUM_ENG; last_grant resets to NUM_ENG-1, so the first grant is engine 0.
REQ-024 eng_finish[k] SHALL clear claimed[k] on the next edge; an engine freed at cycle T SHALL be grantable in S_WaitEng at T+1 or later.
REQ-025 The claimed bitmap SHALL be the only free/busy source; engine busy outputs SHALL be ignored because busy lags start by one cycle.
REQ-026 eng_finish[k] with claimed[k]=0 SHALL set err_spurious, which clears only on rst; if this coincides with a grant to k, the grant SHALL win and claimed[k]=1.
REQ-027 Multiple eng_finish bits in one cycle SHALL all be honoured; outstanding SHALL equal popcount(claimed) and be registered.
REQ-028 drain SHALL set drain_pend; when drain_pend=1 and idle=1, drained SHALL pulse one cycle and drain_pend SHALL clear.
REQ-029 If drain arrives while already idle, drained SHALL pulse on the following cycle.
REQ-030 drain SHALL NOT block input acceptance.

Reset
REQ-031 On rst: state=S_Idle, claimed=0, eng_start=0, drained=0, drain_pend=0, err_spurious=0, outstanding=0, hold register cleared (sym_N, id 0), last_grant=NUM_ENG-1; s_read_ready=1 and idle=1 in the first cycle after reset.
REQ-032 Reset mid-operation SHALL discard the held read and all claims; engines share rst and are reset together, and no eng_start SHALL be emitted in the reset cycle.

Structure
REQ-033 Symbol, sym_N, RID_W and the default engine count constant NUM_SEED_ENG SHALL come from the shared package BwaMemDefines.
REQ-034 Round-robin selection SHALL be a sub-module RrPicker (inputs: request vector, last_grant; outputs: one-hot grant, grant index, any); everything else stays in read_dispatcher.

Verification
REQ-035 Reset, then read id 5 valid at T: eng_start=4'b0001 at T+2, eng_read_id=5, outstanding=1 at T+3, s_read_ready=1 at T+3.
REQ-036 Five back-to-back reads, no finishes: starts go to engines 0,1,2,3; the fifth read waits in S_WaitEng with s_read_ready=0 until eng_finish[2], then eng_start=4'b0100 two cycles later.
REQ-037 Engines 1 and 3 finish in the same cycle with outstanding=4: outstanding=2 the next cycle, and subsequent grants go to 1 then 3 (pointer after 0).
REQ-038 eng_finish[2] with engine 2 unclaimed: err_spurious=1 and stays 1 until rst; outstanding is unchanged.
REQ-039 drain with 2 outstanding: drained pulses exactly once, one cycle after the second finish's clear makes idle=1; drain while idle gives drained at the next cycle.
REQ-040 rst asserted in S_Issue: eng_start low that cycle, then outstanding=0, idle=1, and a following read goes to engine 0.
